// File: rtl/fib_caller_if.sv
// Call/return handshake towards one Fib callee plus the ready/valid result stream.
interface fib_caller_if #(
    parameter int unsigned WIDTH = 32
);
    logic [WIDTH-1:0] fib_n;
    logic             fib_req;
    logic             fib_busy;
    logic [WIDTH-1:0] fib_return;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic [WIDTH-1:0] res_index;

    modport master (
        output fib_n, fib_req, res_valid, res_data, res_index,
        input  fib_busy, fib_return, res_ready
    );

    modport slave (
        input  fib_n, fib_req, res_valid, res_data, res_index,
        output fib_busy, fib_return, res_ready
    );
endinterface

// File: rtl/fib_caller.sv
// Issues N_COUNT sequential calls to a Fib callee, streams each return value out,
// accumulates a wrapping checksum and flags a per-call timeout.
module fib_caller #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned N_START = 0,
    parameter int unsigned N_COUNT = 8,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             run_busy,
    output logic             done,
    output logic             error,
    output logic [WIDTH-1:0] checksum,
    fib_caller_if.master     bus
);
    localparam int unsigned CNT_W  = (N_COUNT > 1) ? $clog2(N_COUNT) : 1;
    localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {S_IDLE, S_CALL, S_WAIT, S_EMIT, S_FINISH} state_e;

    state_e             state_q, state_d;
    logic               fib_req_q, fib_req_d;
    logic [WIDTH-1:0]   fib_n_q, fib_n_d;
    logic               run_busy_q, run_busy_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic               res_valid_q, res_valid_d;
    logic [WIDTH-1:0]   res_data_q, res_data_d;
    logic [WIDTH-1:0]   res_index_q, res_index_d;
    logic [WIDTH-1:0]   checksum_q, checksum_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            fib_req_q   <= 1'b0;
            fib_n_q     <= '0;
            run_busy_q  <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_index_q <= '0;
            checksum_q  <= '0;
            count_q     <= '0;
            wait_q      <= '0;
        end else begin
            state_q     <= state_d;
            fib_req_q   <= fib_req_d;
            fib_n_q     <= fib_n_d;
            run_busy_q  <= run_busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_index_q <= res_index_d;
            checksum_q  <= checksum_d;
            count_q     <= count_d;
            wait_q      <= wait_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        fib_req_d   = 1'b0;
        fib_n_d     = fib_n_q;
        run_busy_d  = run_busy_q;
        done_d      = 1'b0;
        error_d     = error_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_index_d = res_index_q;
        checksum_d  = checksum_q;
        count_d     = count_q;
        wait_d      = wait_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    run_busy_d = 1'b1;
                    error_d    = 1'b0;
                    checksum_d = '0;
                    fib_n_d    = WIDTH'(N_START);
                    count_d    = '0;
                    state_d    = S_CALL;
                end
            end
            S_CALL: begin
                // Busy also covers a callee still in reset or starting up.
                if (!bus.fib_busy) begin
                    fib_req_d = 1'b1;
                    wait_d    = '0;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                wait_d = WAIT_W'(wait_q + 1'b1);
                // Busy is not yet raised in the first WAIT cycle, so skip it.
                if ((wait_q != '0) && !bus.fib_busy) begin
                    res_data_d  = bus.fib_return;
                    res_index_d = fib_n_q;
                    res_valid_d = 1'b1;
                    state_d     = S_EMIT;
                end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
                    error_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_FINISH;
                end
            end
            S_EMIT: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    checksum_d  = checksum_q + res_data_q;
                    count_d     = CNT_W'(count_q + 1'b1);
                    if (count_q == CNT_W'(N_COUNT - 1)) begin
                        done_d  = 1'b1;
                        state_d = S_FINISH;
                    end else begin
                        fib_n_d = fib_n_q + 1'b1;
                        state_d = S_CALL;
                    end
                end
            end
            S_FINISH: begin
                run_busy_d = 1'b0;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign run_busy      = run_busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign checksum      = checksum_q;
    assign bus.fib_n     = fib_n_q;
    assign bus.fib_req   = fib_req_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_index = res_index_q;
endmodule

// File: tb/tb_fib_caller.sv
// Directed bench for fib_caller: two DUT instances, each driving a behavioural Fib callee.
module tb_fib_caller;
    logic clk = 1'b0;
    logic reset;
    logic start_a, start_b;
    logic rdy_a, rdy_b;
    logic busy_a, busy_b, done_a, done_b, err_a, err_b;
    logic [31:0] cks_a, cks_b;

    int checks   = 0;
    int failures = 0;

    fib_caller_if #(.WIDTH(32)) ia ();
    fib_caller_if #(.WIDTH(32)) ib ();

    fib_caller #(.WIDTH(32), .N_START(0), .N_COUNT(8), .TIMEOUT(16)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .run_busy(busy_a), .done(done_a),
        .error(err_a), .checksum(cks_a), .bus(ia.master)
    );
    fib_caller #(.WIDTH(32), .N_START(42), .N_COUNT(1), .TIMEOUT(1024)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .run_busy(busy_b), .done(done_b),
        .error(err_b), .checksum(cks_b), .bus(ib.master)
    );

    always #5 clk = ~clk;

    // Behavioural callees: busy while in reset, then 4 busy cycles per call.
    logic        cb    [2];
    int          lat   [2];
    logic [31:0] fret  [2];
    logic        crst  [2];
    logic        stub  [2];
    logic        req_w [2];
    logic [31:0] n_w   [2];

    assign req_w[0] = ia.fib_req;
    assign req_w[1] = ib.fib_req;
    assign n_w[0]   = ia.fib_n;
    assign n_w[1]   = ib.fib_n;
    assign ia.fib_busy   = cb[0];
    assign ib.fib_busy   = cb[1];
    assign ia.fib_return = fret[0];
    assign ib.fib_return = fret[1];
    assign ia.res_ready  = rdy_a;
    assign ib.res_ready  = rdy_b;

    function automatic logic [31:0] fib_ref(input logic [31:0] n);
        logic [31:0] a, b, t;
        a = 32'd0;
        b = 32'd1;
        for (int i = 0; i < int'(n); i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (crst[k]) begin
                cb[k]  <= 1'b1;
                lat[k] <= 0;
            end else if (!cb[k]) begin
                if (req_w[k]) begin
                    cb[k]   <= 1'b1;
                    lat[k]  <= 4;
                    fret[k] <= fib_ref(n_w[k]);
                end
            end else if (lat[k] > 1) begin
                lat[k] <= lat[k] - 1;
            end else if (!stub[k]) begin
                cb[k]  <= 1'b0;
                lat[k] <= 0;
            end
        end
    end

    // Monitor, sampled on the falling edge.
    logic [31:0] qd_a[$], qi_a[$], qd_b[$], qi_b[$];
    int  done_cnt   [2];
    int  req_cnt    [2];
    bit  req_double [2];
    bit  valid_seen [2];
    bit  req_prev   [2];

    always @(negedge clk) begin
        if (ia.res_valid && ia.res_ready) begin qd_a.push_back(ia.res_data); qi_a.push_back(ia.res_index); end
        if (ib.res_valid && ib.res_ready) begin qd_b.push_back(ib.res_data); qi_b.push_back(ib.res_index); end
        if (ia.res_valid) valid_seen[0] = 1'b1;
        if (ib.res_valid) valid_seen[1] = 1'b1;
        if (ia.fib_req) begin req_cnt[0]++; if (req_prev[0]) req_double[0] = 1'b1; end
        if (ib.fib_req) begin req_cnt[1]++; if (req_prev[1]) req_double[1] = 1'b1; end
        req_prev[0] = ia.fib_req;
        req_prev[1] = ib.fib_req;
        if (done_a) done_cnt[0]++;
        if (done_b) done_cnt[1]++;
    end

    logic [31:0] exp_fib [8] = '{32'd0, 32'd1, 32'd1, 32'd2, 32'd3, 32'd5, 32'd8, 32'd13};

    task automatic clear_mon();
        qd_a.delete(); qi_a.delete(); qd_b.delete(); qi_b.delete();
        for (int k = 0; k < 2; k++) begin
            done_cnt[k] = 0; req_cnt[k] = 0; req_double[k] = 1'b0; valid_seen[k] = 1'b0;
        end
    endtask

    task automatic pulse_start(input int k);
        @(posedge clk); #1;
        if (k == 0) start_a = 1'b1; else start_b = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_done(input int k, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk); #1;
            if (done_cnt[k] > 0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_full_run(input string tag);
        checks++; if (qd_a.size() != 8) begin failures++; $display("FAIL %s_count got=%0d exp=8", tag, qd_a.size()); end
        for (int i = 0; i < 8; i++) begin
            if (i < qd_a.size()) begin
                checks++;
                if (qd_a[i] !== exp_fib[i] || qi_a[i] !== 32'(i)) begin
                    failures++;
                    $display("FAIL %s_result[%0d] got data=%0d idx=%0d exp data=%0d idx=%0d",
                             tag, i, qd_a[i], qi_a[i], exp_fib[i], i);
                end
            end
        end
        checks++; if (cks_a !== 32'd33) begin failures++; $display("FAIL %s_checksum got=%0d exp=33", tag, cks_a); end
        checks++; if (err_a !== 1'b0) begin failures++; $display("FAIL %s_error got=%b exp=0", tag, err_a); end
        checks++; if (done_cnt[0] != 1) begin failures++; $display("FAIL %s_done_pulses got=%0d exp=1", tag, done_cnt[0]); end
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL %s_run_busy_end got=%b exp=0", tag, busy_a); end
    endtask

    task automatic test_reset();
        reset = 1'b1; start_a = 1'b0; start_b = 1'b0; rdy_a = 1'b1; rdy_b = 1'b1;
        crst[0] = 1'b1; crst[1] = 1'b1; stub[0] = 1'b0; stub[1] = 1'b0;
        fret[0] = '0; fret[1] = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy_a !== 1'b0 || done_a !== 1'b0 || err_a !== 1'b0) begin
            failures++; $display("FAIL reset_status got busy=%b done=%b err=%b exp 0 0 0", busy_a, done_a, err_a); end
        checks++; if (ia.fib_req !== 1'b0 || ia.fib_n !== 32'd0) begin
            failures++; $display("FAIL reset_call got req=%b n=%0d exp 0 0", ia.fib_req, ia.fib_n); end
        checks++; if (ia.res_valid !== 1'b0 || ia.res_data !== 32'd0 || ia.res_index !== 32'd0 || cks_a !== 32'd0) begin
            failures++; $display("FAIL reset_result got v=%b d=%0d i=%0d cks=%0d exp all 0",
                                 ia.res_valid, ia.res_data, ia.res_index, cks_a); end
        reset = 1'b0; crst[0] = 1'b0; crst[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        bit ok;
        clear_mon();
        rdy_a = 1'b1;
        pulse_start(0);
        wait_done(0, 400, ok);
        checks++; if (!ok) begin failures++; $display("FAIL basic_done_timeout got=none exp=done"); end
        check_full_run("basic");
        checks++; if (req_cnt[0] != 8 || req_double[0]) begin
            failures++; $display("FAIL basic_req got count=%0d double=%b exp 8 0", req_cnt[0], req_double[0]); end
    endtask

    task automatic test_single();
        bit ok;
        clear_mon();
        pulse_start(1);
        wait_done(1, 400, ok);
        checks++; if (!ok) begin failures++; $display("FAIL single_done_timeout got=none exp=done"); end
        checks++; if (qd_b.size() != 1) begin failures++; $display("FAIL single_count got=%0d exp=1", qd_b.size()); end
        if (qd_b.size() > 0) begin
            checks++; if (qd_b[0] !== 32'h0FF80C38 || qi_b[0] !== 32'd42) begin
                failures++; $display("FAIL single_result got data=%h idx=%0d exp 0ff80c38 42", qd_b[0], qi_b[0]); end
        end
        checks++; if (cks_b !== 32'h0FF80C38) begin failures++; $display("FAIL single_checksum got=%h exp=0ff80c38", cks_b); end
        checks++; if (req_cnt[1] != 1 || req_double[1]) begin
            failures++; $display("FAIL single_req got count=%0d double=%b exp 1 0", req_cnt[1], req_double[1]); end
    endtask

    task automatic test_callee_reset();
        bit ok;
        clear_mon();
        crst[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        pulse_start(0);
        repeat (20) @(posedge clk);
        #1;
        checks++; if (req_cnt[0] != 0 || busy_a !== 1'b1) begin
            failures++; $display("FAIL callee_reset_hold got req=%0d busy=%b exp 0 1", req_cnt[0], busy_a); end
        crst[0] = 1'b0;
        wait_done(0, 400, ok);
        checks++; if (!ok) begin failures++; $display("FAIL callee_reset_done_timeout got=none exp=done"); end
        check_full_run("callee_reset");
    endtask

    task automatic test_stall();
        bit ok, got, bad;
        logic [31:0] d0, i0;
        clear_mon();
        rdy_a = 1'b0;
        pulse_start(0);
        for (int k = 0; k < 8; k++) begin
            got = 1'b0;
            for (int c = 0; c < 200; c++) begin
                if (ia.res_valid) begin got = 1'b1; break; end
                @(posedge clk); #1;
            end
            checks++; if (!got) begin failures++; $display("FAIL stall_valid_timeout[%0d] got=none exp=valid", k); break; end
            if (k == 2) begin
                d0 = ia.res_data; i0 = ia.res_index; bad = 1'b0;
                repeat (10) begin
                    @(posedge clk); #1;
                    if (!ia.res_valid || ia.res_data !== d0 || ia.res_index !== i0 || ia.fib_req) bad = 1'b1;
                end
                checks++; if (bad) begin failures++; $display("FAIL stall_stable got=changed exp=held"); end
                checks++; if (d0 !== 32'd1 || i0 !== 32'd2) begin
                    failures++; $display("FAIL stall_third got data=%0d idx=%0d exp 1 2", d0, i0); end
            end
            rdy_a = 1'b1;
            @(posedge clk); #1;
            rdy_a = 1'b0;
        end
        wait_done(0, 100, ok);
        checks++; if (!ok) begin failures++; $display("FAIL stall_done_timeout got=none exp=done"); end
        check_full_run("stall");
        rdy_a = 1'b1;
    endtask

    task automatic test_timeout();
        bit ok;
        clear_mon();
        stub[0] = 1'b1;
        pulse_start(0);
        wait_done(0, 200, ok);
        checks++; if (!ok) begin failures++; $display("FAIL timeout_done_missing got=none exp=done"); end
        checks++; if (err_a !== 1'b1) begin failures++; $display("FAIL timeout_error got=%b exp=1", err_a); end
        checks++; if (valid_seen[0] || req_cnt[0] != 1 || done_cnt[0] != 1) begin
            failures++; $display("FAIL timeout_activity got valid=%b req=%0d done=%0d exp 0 1 1",
                                 valid_seen[0], req_cnt[0], done_cnt[0]); end
        stub[0] = 1'b0;
        clear_mon();
        pulse_start(0);
        checks++; if (err_a !== 1'b0) begin failures++; $display("FAIL timeout_error_clear got=%b exp=0", err_a); end
        wait_done(0, 400, ok);
        checks++; if (!ok) begin failures++; $display("FAIL timeout_rerun_timeout got=none exp=done"); end
        check_full_run("timeout_rerun");
    endtask

    task automatic test_mid_reset();
        bit ok, got;
        clear_mon();
        pulse_start(0);
        got = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            if (req_cnt[0] >= 4) begin got = 1'b1; break; end
        end
        checks++; if (!got) begin failures++; $display("FAIL mid_reset_reach got=none exp=4th_call"); end
        @(posedge clk); #1;
        checks++; if (ia.fib_n !== 32'd3 || cks_a !== 32'd2 || ia.res_index !== 32'd2) begin
            failures++; $display("FAIL mid_reset_pre got n=%0d cks=%0d idx=%0d exp 3 2 2", ia.fib_n, cks_a, ia.res_index); end
        #2 reset = 1'b1;
        #1;
        checks++; if (busy_a !== 1'b0 || ia.fib_req !== 1'b0 || ia.fib_n !== 32'd0 || done_a !== 1'b0 || err_a !== 1'b0) begin
            failures++; $display("FAIL mid_reset_ctrl got busy=%b req=%b n=%0d done=%b err=%b exp all 0",
                                 busy_a, ia.fib_req, ia.fib_n, done_a, err_a); end
        checks++; if (ia.res_valid !== 1'b0 || ia.res_data !== 32'd0 || ia.res_index !== 32'd0 || cks_a !== 32'd0) begin
            failures++; $display("FAIL mid_reset_data got v=%b d=%0d i=%0d cks=%0d exp all 0",
                                 ia.res_valid, ia.res_data, ia.res_index, cks_a); end
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        clear_mon();
        pulse_start(0);
        wait_done(0, 400, ok);
        checks++; if (!ok) begin failures++; $display("FAIL mid_reset_rerun_timeout got=none exp=done"); end
        check_full_run("mid_reset_rerun");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single();
        test_callee_reset();
        test_stall();
        test_timeout();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/fib_caller.md
Name: fib_caller

Overview:
- Initiator for the req/busy method-call handshake that the generated Fib callee exposes on fib_n/fib_req/fib_busy/fib_return.
- On start, issues N_COUNT sequential calls with n = N_START, N_START+1, …, captures each return value, and emits it on a ready/valid result stream.
- Keeps a wrapping checksum and a call-timeout watchdog.
- Sits between a testbench or host controller and one Fib callee instance.

Parameters:
WIDTH, 32, data width of n, return value, result and checksum
N_START, 0, first n issued
N_COUNT, 8, number of calls per run (≥1)
TIMEOUT, 1024, maximum cycles allowed in WAIT before error

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse; begins a run when run_busy=0
run_busy  out  1  high from cycle after accepted start until return to IDLE
done  out  1  one-cycle pulse when run finishes (normal or error)
error  out  1  sticky timeout flag; cleared by next accepted start
fib_n  out  WIDTH  argument to callee; registered, held stable
fib_req  out  1  call request to callee; registered, exactly one-cycle pulse per call
fib_busy  in  1  callee busy; high out of callee reset, low when callee idle
fib_return  in  WIDTH  callee result; valid once fib_busy falls after a call
res_valid  out  1  result available
res_ready  in  1  result consumer ready
res_data  out  WIDTH  captured fib_return
res_index  out  WIDTH  n that produced res_data
checksum  out  WIDTH  sum mod 2^WIDTH of results emitted this run

Behaviour:
- Reset (async, any state):
  - state=IDLE; fib_req=0; fib_n=0; run_busy=0; done=0; error=0; res_valid=0; res_data=0; res_index=0; checksum=0.
  - Call counter and wait counter = 0.
- State IDLE:
  - start=1 → run_busy<=1, error<=0, checksum<=0, fib_n<=N_START, count<=0, go to CALL.
  - start in any other state is ignored.
- State CALL:
  - Wait while fib_busy=1 (covers callee still in reset/startup).
  - When fib_busy=0: fib_req<=1 for one cycle, wait counter<=0, go to WAIT.
  - fib_n is stable from at least the cycle before fib_req through the end of WAIT.
- State WAIT:
  - fib_req<=0. Wait counter increments every cycle.
  - fib_busy is ignored while wait counter=0; the callee raises busy only one cycle after the req.
  - Completion: wait counter≥1 and fib_busy=0 → res_data<=fib_return, res_index<=fib_n, res_valid<=1, go to EMIT.
  - Timeout: wait counter reaches TIMEOUT before completion → error<=1, go to FINISH; no result emitted.
- State EMIT:
  - res_valid, res_data and res_index held stable until res_ready=1.
  - On handshake (res_valid & res_ready): res_valid<=0, checksum<=checksum+res_data (wraps), count<=count+1.
  - If count+1=N_COUNT → go to FINISH; else fib_n<=fib_n+1 and go to CALL.
  - No new call is issued until the result is accepted (single-entry buffer, no overlap).
- State FINISH: done=1 for one cycle, run_busy<=0, go to IDLE.
  - checksum and error hold until the next accepted start.
- Latency per call = callee latency + 2 cycles minimum, plus any consumer stall.
- fib_n increment wraps at 2^WIDTH; it is not checked.
- res_ready while res_valid=0 has no effect.

Test Plan:
- Default params, callee attached, res_ready=1, start pulse → 8 results, res_index 0..7, res_data 0,1,1,2,3,5,8,13. Then checksum=33, done pulses once, error=0.
- N_START=42, N_COUNT=1 → single result res_data=267914296 (0x0FF80C38), checksum equal to it. fib_req is high exactly one cycle.
- Start asserted while the callee is still held in reset (fib_busy=1 for 20 cycles) → fib_req stays 0 until fib_busy falls. The run then completes normally.
- res_ready low for 10 cycles on the 3rd result → res_valid/res_data/res_index stable throughout the stall. No fib_req during the stall; final checksum is still 33.
- Callee replaced by a stub holding fib_busy=1 after the req, TIMEOUT=16 → error=1 and done pulse after the WAIT timeout. No res_valid; next start clears error.
- Reset asserted mid-WAIT on the 4th call → all outputs drop to reset values immediately (async). A subsequent start restarts from N_START with checksum 0.
